matmul_bwd: RTL and testbench
=============================

Name: matmul_bwd

Overview:
Backward-pass counterpart of the forward matrix-vector layer. It computes the input gradient grad_in = W^T * grad_out, where W is the same OUT_DIM x IN_DIM weight array the forward layer uses. The block is sequential: it walks the OUT_DIM rows one per cycle, running IN_DIM parallel multiply-accumulate lanes. It sits between the loss/next-layer gradient source and the previous layer's backward block, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, element width; signed two's complement
IN_DIM, 1, forward input dimension; length of grad_in
OUT_DIM, 1, forward output dimension; length of grad_out

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  grad_out and weights are valid
in_ready  output  1  block can accept an operand set
weights  input  DATA_W [OUT_DIM][IN_DIM]  weight matrix, row = output index
grad_out  input  DATA_W [OUT_DIM]  upstream gradient
out_valid  output  1  grad_in is valid
out_ready  input  1  downstream accepts grad_in
grad_in  output  DATA_W [IN_DIM]  input gradient, registered

Behaviour:
- Reset: sampled on a clk edge while rst_n=0. State goes to IDLE. in_ready=0 during reset, and 1 on the first cycle after release. out_valid=0. grad_in all 0. Accumulators, row counter and operand registers are all 0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture weights and grad_out into internal registers, clear the accumulators, set row=0, and go to ACC.
  - ACC: in_ready=0. Each cycle, for every i: acc[i] += grad_out_r[row] * w_r[row][i]. When row==OUT_DIM-1, go to DONE and load grad_in from the final sums on the same edge. Otherwise row++.
  - DONE: out_valid=1 and grad_in is held stable. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency:
  - Accept edge to out_valid=1 is OUT_DIM+1 clk edges.
  - Throughput is one operand set per OUT_DIM+2 cycles when out_ready is held at 1.
  - There is no overlap: in_ready=0 throughout ACC and DONE.
- Arithmetic:
  - Products are computed at 2*DATA_W and truncated to the low DATA_W bits.
  - Accumulation wraps modulo 2^DATA_W.
  - This matches the forward layer's modular semantics, so there is no saturation.
- Input stability: inputs are sampled only on the accept edge. Changes to weights or grad_out afterwards have no effect on the current result.
- OUT_DIM=1: ACC lasts exactly one cycle. Row counter width is max(1,$clog2(OUT_DIM)).
- Backpressure: out_valid stays high and grad_in stays constant until out_ready. in_valid asserted meanwhile is ignored and not lost; the source holds it per the handshake.
- Reset mid-operation (ACC or DONE): abort, and go to IDLE with every output at its reset value. No partial result is emitted.
- in_valid is ignored while in_ready=0.

Optional Feature:
Macro MATMUL_BWD_RELU_MASK_EN applies the ReLU derivative to the result.
- Defined:
  - Adds port act_in, input, DATA_W [IN_DIM]: the forward pre-activation values, captured with the operands at accept.
  - At the ACC to DONE transition, grad_in[i] = 0 where act_in_r[i] is signed <= 0; otherwise grad_in[i] = acc[i].
  - Latency is unchanged.
- Undefined: the act_in port is absent and grad_in = acc unmasked.

Decomposition:
- Shared package ml_pkg holds:
  - the state typedef: enum IDLE/ACC/DONE, 2 bits;
  - the helper function for row counter width.
- Sub-module mac_lane, instanced IN_DIM times:
  - holds one DATA_W accumulator, with clear, enable, a and b inputs;
  - registers acc <= clear ? 0 : acc + a*b (low DATA_W bits) when enabled.
- Top level holds the FSM, row counter, operand registers and output register.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Expect out_valid=0 and grad_in=0 throughout; in_ready=0 during reset and 1 the cycle after release.
- Basic case with IN_DIM=2, OUT_DIM=3:
  - Stimulus: W=[[1,2],[3,4],[5,6]], grad_out=[1,1,2], out_ready=1.
  - Expect out_valid exactly 4 edges after accept, with grad_in=[14,18].
- Signed and wrap (DATA_W=8, IN_DIM=1, OUT_DIM=2):
  - W=[[-3],[100]], grad_out=[5,2]: expect grad_in=-15+200=185, which is -71 mod 256 (0xB9).
  - W=[[16],[0]], grad_out=[16,0]: expect 0x00.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new operands driven. Expect grad_in stable, in_ready=0 and no second accept. After out_ready, the next set is accepted and its result is correct.
- Reset mid-ACC: with OUT_DIM=3, assert rst_n=0 after 1 ACC cycle. Expect no out_valid and grad_in=0. A new operation afterwards yields a correct result, with no leftover accumulation.
- Mask, with MATMUL_BWD_RELU_MASK_EN defined: basic case plus act_in=[-1,7]. Expect grad_in=[0,18]. With act_in=[0,0], expect [0,0].

Source files
------------

// File: rtl/ml_pkg.sv
// Shared types and helpers for the matmul_bwd slice: FSM state encoding and
// the row-counter width rule used by the sequential backward layer.
package ml_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row counter needs at least one bit even when there is a single row.
    function automatic int row_cnt_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/matmul_bwd_mac_lane.sv
// mac_lane: one multiply-accumulate lane of the backward layer. Holds a
// DATA_W accumulator that wraps modulo 2^DATA_W. The 'sum' output exposes
// acc + a*b so the parent can capture the final total on the same edge
// the last product is accumulated.
module mac_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] prod_s;

    // The low DATA_W bits of a two's complement product do not depend on
    // signedness or on the upper half, so a DATA_W-wide multiply suffices.
    assign prod_s = a * b;
    assign sum    = acc_r + prod_s;

    // Accumulator register: clear on a new operand set, otherwise add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {DATA_W{1'b0}};
        end else if (en) begin
            if (clear) begin
                acc_r <= {DATA_W{1'b0}};
            end else begin
                acc_r <= sum;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/matmul_bwd.sv
// matmul_bwd: grad_in = W^T * grad_out, one weight row per cycle with IN_DIM
// parallel MAC lanes. Valid/ready on both sides, no overlap between sets.
// Optional macro MATMUL_BWD_RELU_MASK_EN adds act_in and zeroes grad_in
// lanes whose captured pre-activation is <= 0 (ReLU derivative).
module matmul_bwd
    import ml_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IN_DIM  = 1,
    parameter int OUT_DIM = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [OUT_DIM-1:0][IN_DIM-1:0][DATA_W-1:0] weights,
    input  logic [OUT_DIM-1:0][DATA_W-1:0]         grad_out,
`ifdef MATMUL_BWD_RELU_MASK_EN
    input  logic [IN_DIM-1:0][DATA_W-1:0]          act_in,
`endif
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [IN_DIM-1:0][DATA_W-1:0]          grad_in
);

    localparam int ROW_W = row_cnt_w(OUT_DIM);

    state_t                                 state_r;
    state_t                                 state_s;
    logic [ROW_W-1:0]                       row_r;
    logic [OUT_DIM-1:0][IN_DIM-1:0][DATA_W-1:0] w_r;
    logic [OUT_DIM-1:0][DATA_W-1:0]         go_r;
    logic                                   in_ready_r;
    logic                                   out_valid_r;
    logic [IN_DIM-1:0][DATA_W-1:0]          grad_in_r;
    logic [IN_DIM-1:0][DATA_W-1:0]          sum_s;
    logic [IN_DIM-1:0][DATA_W-1:0]          result_s;
    logic                                   accept_s;
    logic                                   last_s;
    logic                                   lane_clr_s;
    logic                                   lane_en_s;
`ifdef MATMUL_BWD_RELU_MASK_EN
    logic [IN_DIM-1:0][DATA_W-1:0]          act_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign grad_in   = grad_in_r;
    assign last_s    = (row_r == ROW_W'(OUT_DIM - 1));

    // Next-state and lane-control decode.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        lane_clr_s = 1'b0;
        lane_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    lane_clr_s = 1'b1;
                    lane_en_s  = 1'b1;
                    state_s    = ACC;
                end else begin
                    state_s    = IDLE;
                end
            end
            ACC: begin
                lane_en_s = 1'b1;
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Final lane values, optionally gated by the ReLU derivative.
    always_comb begin
        result_s = sum_s;
`ifdef MATMUL_BWD_RELU_MASK_EN
        for (int i = 0; i < IN_DIM; i++) begin
            if ($signed(act_r[i]) <= $signed({DATA_W{1'b0}})) begin
                result_s[i] = {DATA_W{1'b0}};
            end else begin
                result_s[i] = sum_s[i];
            end
        end
`endif
    end

    // State, row counter, operand capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            row_r       <= {ROW_W{1'b0}};
            w_r         <= '0;
            go_r        <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            grad_in_r   <= '0;
`ifdef MATMUL_BWD_RELU_MASK_EN
            act_r       <= '0;
`endif
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            if (accept_s) begin
                w_r   <= weights;
                go_r  <= grad_out;
                row_r <= {ROW_W{1'b0}};
`ifdef MATMUL_BWD_RELU_MASK_EN
                act_r <= act_in;
`endif
            end else if ((state_r == ACC) && !last_s) begin
                row_r <= row_r + ROW_W'(1);
            end else begin
                row_r <= row_r;
            end
            if ((state_r == ACC) && last_s) begin
                grad_in_r <= result_s;
            end else begin
                grad_in_r <= grad_in_r;
            end
        end
    end

    for (genvar i = 0; i < IN_DIM; i++) begin : g_lane
        mac_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (lane_clr_s),
            .en    (lane_en_s),
            .a     (go_r[row_r]),
            .b     (w_r[row_r][i]),
            .sum   (sum_s[i])
        );
    end

endmodule

// File: tb/tb_matmul_bwd.sv
// Bench for matmul_bwd: an 8-bit 2x3 instance for directed, wrap, backpressure,
// mid-operation reset and random cases, plus a 32-bit 1x1 instance for the
// single-row boundary. Expected values come from plain integer arithmetic.
module tb_matmul_bwd;

`ifdef MATMUL_BWD_RELU_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic                 in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [2:0][1:0][7:0] w_a;
    logic [2:0][7:0]      g_a;
    logic [1:0][7:0]      act_a;
    logic [1:0][7:0]      grad_in_a;

    logic                  in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [0:0][0:0][31:0] w_b;
    logic [0:0][31:0]      g_b;
    logic [0:0][31:0]      act_b;
    logic [0:0][31:0]      grad_in_b;

    int passed = 0;
    int total  = 0;

    matmul_bwd #(.DATA_W(8), .IN_DIM(2), .OUT_DIM(3)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .weights   (w_a),
        .grad_out  (g_a),
`ifdef MATMUL_BWD_RELU_MASK_EN
        .act_in    (act_a),
`endif
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .grad_in   (grad_in_a)
    );

    matmul_bwd #(.DATA_W(32), .IN_DIM(1), .OUT_DIM(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .weights   (w_b),
        .grad_out  (g_b),
`ifdef MATMUL_BWD_RELU_MASK_EN
        .act_in    (act_b),
`endif
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .grad_in   (grad_in_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: grad_in[i] = sum_k g[k]*W[k][i], wrapped to 8 bits.
    function automatic logic [15:0] model_a(input logic [2:0][1:0][7:0] w,
                                            input logic [2:0][7:0] g,
                                            input logic [1:0][7:0] act);
        logic [1:0][7:0] r;
        int s;
        for (int i = 0; i < 2; i++) begin
            s = 0;
            for (int k = 0; k < 3; k++) s += int'($signed(g[k])) * int'($signed(w[k][i]));
            r[i] = s[7:0];
            if (MASK_EN && ($signed(act[i]) <= 0)) r[i] = 8'd0;
        end
        return r;
    endfunction

    task automatic wait_accept_a();
        logic was = 1'b0;
        for (int n = 0; n < 20 && !was; n++) begin
            was = in_ready_a;
            @(posedge clk); #1;
        end
        chk("accept_a", was, 1'b1);
    endtask

    // After the accept edge: busy for OUT_DIM-1 edges, valid on edge OUT_DIM
    // (OUT_DIM+1 edges counting the accept edge), hold, then handshake.
    task automatic finish_a(input logic [15:0] exp, input int hold);
        out_ready_a = (hold == 0);
        for (int k = 1; k < 3; k++) begin
            @(posedge clk); #1;
            chk("busy_valid_a", out_valid_a, 1'b0);
            chk("busy_ready_a", in_ready_a, 1'b0);
        end
        @(posedge clk); #1;
        chk("done_valid_a", out_valid_a, 1'b1);
        chk("result_a", grad_in_a, exp);
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid_a", out_valid_a, 1'b1);
            chk("hold_result_a", grad_in_a, exp);
            chk("hold_ready_a", in_ready_a, 1'b0);
        end
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("post_valid_a", out_valid_a, 1'b0);
        chk("post_ready_a", in_ready_a, 1'b1);
    endtask

    task automatic randomize_a();
        for (int k = 0; k < 3; k++) begin
            g_a[k] = 8'($urandom);
            for (int i = 0; i < 2; i++) w_a[k][i] = 8'($urandom);
        end
        for (int i = 0; i < 2; i++) act_a[i] = 8'($urandom);
    endtask

    task automatic run_b();
        logic        was = 1'b0;
        logic [63:0] p;
        logic [31:0] exp;
        w_b[0][0] = $urandom;
        g_b[0]    = $urandom;
        act_b[0]  = $urandom;
        p   = 64'(longint'($signed(g_b[0])) * longint'($signed(w_b[0][0])));
        exp = p[31:0];
        if (MASK_EN && ($signed(act_b[0]) <= 0)) exp = 32'd0;
        in_valid_b = 1'b1;
        for (int n = 0; n < 20 && !was; n++) begin
            was = in_ready_b;
            @(posedge clk); #1;
        end
        chk("accept_b", was, 1'b1);
        in_valid_b = 1'b0;
        @(posedge clk); #1;
        chk("done_valid_b", out_valid_b, 1'b1);
        chk("result_b", grad_in_b, exp);
        @(posedge clk); #1;
        chk("post_valid_b", out_valid_b, 1'b0);
    endtask

    initial begin
        logic [15:0] exp1;
        logic [15:0] exp2;
        rst_n = 1'b0;
        in_valid_a = 1'b0; out_ready_a = 1'b1; w_a = '0; g_a = '0; act_a = {8'd1, 8'd1};
        in_valid_b = 1'b0; out_ready_b = 1'b1; w_b = '0; g_b = '0; act_b = '0;

        // Reset held for three cycles.
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ready_a", in_ready_a, 1'b0);
            chk("rst_valid_a", out_valid_a, 1'b0);
            chk("rst_grad_a", grad_in_a, 16'd0);
            chk("rst_ready_b", in_ready_b, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready_a", in_ready_a, 1'b1);
        chk("rel_valid_a", out_valid_a, 1'b0);
        chk("rel_ready_b", in_ready_b, 1'b1);

        // Basic: W=[[1,2],[3,4],[5,6]], grad_out=[1,1,2] -> [14,18].
        w_a[0] = {8'd2, 8'd1}; w_a[1] = {8'd4, 8'd3}; w_a[2] = {8'd6, 8'd5};
        g_a = {8'd2, 8'd1, 8'd1};
        in_valid_a = 1'b1;
        wait_accept_a();
        in_valid_a = 1'b0;
        finish_a({8'd18, 8'd14}, 0);

        // Signed wrap: -3*5 + 100*2 = 185 -> 0xB9.
        w_a[0] = {8'd0, 8'hFD}; w_a[1] = {8'd0, 8'd100}; w_a[2] = '0;
        g_a = {8'd0, 8'd2, 8'd5};
        in_valid_a = 1'b1;
        wait_accept_a();
        in_valid_a = 1'b0;
        finish_a({8'h00, 8'hB9}, 0);

        // 16*16 wraps to zero.
        w_a[0] = {8'd0, 8'd16}; w_a[1] = '0; w_a[2] = '0;
        g_a = {8'd0, 8'd0, 8'd16};
        in_valid_a = 1'b1;
        wait_accept_a();
        in_valid_a = 1'b0;
        finish_a(16'h0000, 0);

`ifdef MATMUL_BWD_RELU_MASK_EN
        w_a[0] = {8'd2, 8'd1}; w_a[1] = {8'd4, 8'd3}; w_a[2] = {8'd6, 8'd5};
        g_a = {8'd2, 8'd1, 8'd1};
        act_a = {8'd7, 8'hFF};
        in_valid_a = 1'b1;
        wait_accept_a();
        in_valid_a = 1'b0;
        finish_a({8'd18, 8'd0}, 0);
        act_a = {8'd0, 8'd0};
        in_valid_a = 1'b1;
        wait_accept_a();
        in_valid_a = 1'b0;
        finish_a(16'h0000, 0);
`endif

        // Backpressure with a second set pending; operands change after accept.
        randomize_a();
        exp1 = model_a(w_a, g_a, act_a);
        in_valid_a = 1'b1;
        wait_accept_a();
        randomize_a();
        exp2 = model_a(w_a, g_a, act_a);
        finish_a(exp1, 5);
        wait_accept_a();
        in_valid_a = 1'b0;
        finish_a(exp2, 0);

        // Reset one cycle into ACC aborts the operation.
        randomize_a();
        in_valid_a = 1'b1;
        wait_accept_a();
        in_valid_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid_a", out_valid_a, 1'b0);
        chk("abort_grad_a", grad_in_a, 16'd0);
        chk("abort_ready_a", in_ready_a, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_ready_a", in_ready_a, 1'b1);
        chk("abort_rel_valid_a", out_valid_a, 1'b0);

        // Random operand sets with random backpressure.
        for (int t = 0; t < 6; t++) begin
            randomize_a();
            exp1 = model_a(w_a, g_a, act_a);
            in_valid_a = 1'b1;
            wait_accept_a();
            in_valid_a = 1'b0;
            finish_a(exp1, int'($urandom_range(0, 3)));
        end

        // Single-row instance: ACC lasts one cycle.
        for (int t = 0; t < 4; t++) run_b();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
